// File: rtl/uart_rx_stream.sv
// uart_rx_stream: oversampled 8N1 UART receiver feeding a show-ahead byte FIFO on a valid/ready master port.
// Optional feature macro UART_RX_PARITY_EN adds an even-parity bit per frame and a parity_err pulse output.
module uart_rx_stream #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               rx_in,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               frame_err,
  output logic               overflow,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  output logic [FIFO_AW:0]   fifo_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t             state;
  logic [CW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               sync1, rx_s;
`ifdef UART_RX_PARITY_EN
  logic               par_bit;
`endif

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               full, pop, stop_hit, byte_ok, push, ovf_now, par_bad;

  // Synchroniser resets high so the idle line never looks like a start bit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  always_comb begin
`ifdef UART_RX_PARITY_EN
    par_bad  = ^{shreg, par_bit};
`else
    par_bad  = 1'b0;
`endif
    full     = (fifo_count == (FIFO_AW+1)'(FIFO_DEPTH));
    pop      = m_tvalid && m_tready;
    stop_hit = (state == STOP) && (baud_cnt == '0) && rx_s;
    byte_ok  = stop_hit && !par_bad;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    push     = byte_ok && (!full || pop);
    ovf_now  = byte_ok && full && !pop;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      overflow   <= ovf_now;
`ifdef UART_RX_PARITY_EN
      parity_err <= stop_hit && par_bad;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            baud_cnt <= FULL_LOAD;
            bit_idx  <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else begin
            shreg    <= {rx_s, shreg[7:1]};
            baud_cnt <= FULL_LOAD;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else begin
            par_bit  <= rx_s;
            baud_cnt <= FULL_LOAD;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + (FIFO_AW+1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (FIFO_AW+1)'(1);
    end
  end

  assign m_tvalid = (fifo_count != '0);
  assign m_tdata  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 16 clocks/bit with a 4-entry FIFO; scoreboard of expected bytes.
// Build with UART_RX_PARITY_EN to also exercise the parity frames.
module tb_uart_rx_stream;
  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Clock edge (counted from the start-bit drive) at which the stop bit is sampled.
  localparam int SAMPLE = 3 + BIT / 2 + (9 + PB) * BIT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_stream #(.CLKS_PER_BIT(BIT), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .rx_in     (rx),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .frame_err (frame_err),
    .overflow  (overflow),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_mem[64];
  int         n_beats = 0;
  int         rd_idx = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;

  // Monitor: records every accepted beat and counts pulse cycles.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      got_mem[n_beats[5:0]] <= m_tdata;
      n_beats <= n_beats + 1;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overflow)  ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    logic pbit;
    pbit = (^d) ^ ~par_ok;
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (PB == 1) hold(pbit, BIT);
    hold(stop_ok, BIT);
    rx = 1'b1;
  endtask

  task automatic check_beats(input string tag);
    logic [7:0] e;
    int waited;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (n_beats <= rd_idx && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      tests++;
      assert (n_beats > rd_idx) else begin
        fails++;
        $error("FAIL %s_timeout: observed %0d beats expected more than %0d", tag, n_beats, rd_idx);
      end
      if (n_beats > rd_idx) begin
        chk(tag, got_mem[rd_idx[5:0]], e);
        rd_idx++;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_beat_count"}, n_beats, rd_idx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, pe0, nb0;
    rst_n = 1'b0;
    rx = 1'b1;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
`ifdef UART_RX_PARITY_EN
    chk("rst_parity_err", parity_err, 0);
`endif
    rst_n = 1'b1;
    hold(1'b1, 10);

    // Basic byte
    m_tready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_beats("a5");
    chk("a5_frame_err", fe_cnt - fe0, 0);
    chk("a5_overflow", ov_cnt - ov0, 0);
    chk("a5_count", fifo_count, 0);

    // Glitch then valid byte
    nb0 = n_beats;
    hold(1'b0, 5);
    hold(1'b1, 30);
    chk("glitch_nobeat", n_beats, nb0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_beats("3c");

    // Framing error with held-low line
    fe0 = fe_cnt; nb0 = n_beats;
    send_frame(8'h55, 1'b0, 1'b1);
    hold(1'b0, 40);
    hold(1'b1, 32);
    chk("fe_pulses", fe_cnt - fe0, 1);
    chk("fe_nobeat", n_beats, nb0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_beats("after_fe");

    // Overflow with consumer stalled
    m_tready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'(8'h10 + i));
      send_frame(8'(8'h10 + i), 1'b1, 1'b1);
      hold(1'b1, 4);
    end
    hold(1'b1, 20);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_pulses", ov_cnt - ov0, 1);
    chk("ovf_tvalid", m_tvalid, 1);
    chk("ovf_head", m_tdata, 8'h10);
    m_tready = 1'b1;
    check_beats("ovf_drain");
    chk("ovf_drained", fifo_count, 0);

    // Full FIFO with a pop on the exact push cycle
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send_frame(8'(8'h20 + i), 1'b1, 1'b1);
      hold(1'b1, 4);
    end
    exp_q.push_back(8'h24);
    ov0 = ov_cnt;
    fork
      send_frame(8'h24, 1'b1, 1'b1);
      begin
        repeat (SAMPLE - 1) @(posedge clk);
        #1 m_tready = 1'b1;
        @(posedge clk);
        #1 m_tready = 1'b0;
      end
    join
    hold(1'b1, 20);
    chk("sim_overflow", ov_cnt - ov0, 0);
    chk("sim_count", fifo_count, 4);
    chk("sim_head", m_tdata, 8'h21);
    m_tready = 1'b1;
    check_beats("sim_drain");

    // Reset in the middle of a frame with a byte waiting
    m_tready = 1'b0;
    send_frame(8'h42, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("pre_rst_count", fifo_count, 1);
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; nb0 = n_beats;
    hold(1'b0, BIT);
    hold(1'b1, 2 * BIT + 5);
    rst_n = 1'b0;
    hold(1'b1, 3);
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    hold(1'b1, 20);
    rst_n = 1'b1;
    m_tready = 1'b1;
    hold(1'b1, 30);
    chk("mid_rst_fe", fe_cnt - fe0, 0);
    chk("mid_rst_ovf", ov_cnt - ov0, 0);
    chk("mid_rst_pe", pe_cnt - pe0, 0);
    chk("mid_rst_nobeat", n_beats, nb0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_beats("81");

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt; nb0 = n_beats; fe0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("par_pulses", pe_cnt - pe0, 1);
    chk("par_nobeat", n_beats, nb0);
    chk("par_no_fe", fe_cnt - fe0, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_beats("par_good");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Serial receive stage for the board UART. Consumes the `RS232_Uart_1_sout` line driven by the system and turns it into bytes on an AXI4-Stream-style master port.
- Bytes are buffered in a small FIFO so a slow checker or downstream consumer never drops characters.
- Runs entirely on the 100 MHz system clock; the asynchronous serial line is oversampled.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per serial bit (115200 baud at 100 MHz); legal range >= 8.
- FIFO_DEPTH, 16, byte entries in the receive FIFO; power of 2, >= 2.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = in reset); deasserted synchronously to CLK.
- rx_in  in  1  serial line; idle high, 8N1, LSB first.
- m_tdata  out  8  received byte at the FIFO head.
- m_tvalid  out  1  FIFO not empty.
- m_tready  in  1  consumer accepts m_tdata when m_tvalid && m_tready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  one-cycle pulse: byte completed while the FIFO was full.
- fifo_count  out  FIFO_AW+1  current occupancy.

Behaviour:
- Reset (RESET=0, asynchronous):
  - FSM goes to IDLE; bit counter and baud counter are 0.
  - Synchroniser flops are set to 1.
  - FIFO is emptied: fifo_count=0, m_tvalid=0, m_tdata=0.
  - frame_err=0, overflow=0.
  - A frame in progress is discarded, with no pulse.
- Synchroniser: rx_in passes through 2 flops to give rx_s. All decisions use rx_s (2-cycle input latency).
- IDLE:
  - On rx_s==0, load baud counter with CLKS_PER_BIT/2 - 1 and go to START.
- START:
  - When the counter reaches 0, sample rx_s.
  - If 1: false start; return to IDLE with no output.
  - If 0: load CLKS_PER_BIT-1, bit index=0, go to DATA.
- DATA:
  - Each counter expiry, shift rx_s into the MSB of the shift register (LSB-first order), reload the counter, increment the index.
  - After 8 bits go to PARITY if enabled, else STOP.
- STOP: at counter expiry, sample rx_s.
  - rx_s=1 and FIFO not full: push the byte. m_tvalid rises the next cycle. Go to IDLE.
  - rx_s=1 and FIFO full: drop the byte, pulse overflow for 1 cycle, go to IDLE.
  - rx_s=0: drop the byte, pulse frame_err for 1 cycle, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. Prevents a held-low line from generating repeated frames.
- FIFO:
  - Circular buffer with FIFO_AW-bit read and write pointers that wrap modulo FIFO_DEPTH.
  - m_tdata is the head entry (show-ahead).
  - Pop on m_tvalid && m_tready.
  - Simultaneous push and pop: count is unchanged. This is allowed even when full, because the pop frees the slot in the same cycle, so no overflow occurs.
  - Pop when empty is ignored (m_tvalid=0).
  - m_tdata is stable while m_tvalid=1 and m_tready=0.
- End-to-end latency: rx_in falling edge to m_tvalid = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+CLKS_PER_BIT with parity), ±1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA that samples one extra bit and checks even parity (XOR of the 8 data bits and the parity bit must be 0).
  - On mismatch, the byte is dropped at STOP even when the stop bit is good.
  - Adds output port parity_err (1 bit, reset 0), pulsed for 1 cycle at the stop-bit sample.
  - Frame error takes priority: if the stop bit is bad, frame_err pulses and parity_err does not.
- Undefined: no PARITY state, no parity_err port; frames are 8N1.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 0xA5 (8N1), m_tready=1 -> one m_tvalid beat with m_tdata=0xA5; frame_err=0, overflow=0; fifo_count returns to 0.
- rx_in low for 5 cycles then high (glitch) -> no beat, FSM back in IDLE. A following 0x3C is received correctly.
- Send 0x55 with the stop bit forced low, then hold rx_in low for 40 cycles -> exactly one frame_err pulse, no beat. The next 0x01 after the line idles is received.
- m_tready=0, send 0x10..0x14 (5 bytes) -> fifo_count=4, one overflow pulse at the 5th stop bit. Raising m_tready then yields 0x10,0x11,0x12,0x13 in order.
- FIFO full with m_tready=1 at the exact cycle a new byte completes -> no overflow, count stays 4, new byte appears last.
- Assert RESET=0 mid-DATA of 0xFF -> m_tvalid=0, fifo_count=0, no pulses. After release, 0x81 is received. With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no beat.
